// File: rtl/frame_capture_pkg.sv
// Shared types and constants for the frame capture scheduler.
// Build option: define CAPTURE_STATS_EN to add per-channel capture_count outputs.
package frame_capture_pkg;

   // Per-channel scheduler states
   typedef enum logic [1:0] {
      ST_IDLE       = 2'd0,
      ST_COUNT      = 2'd1,
      ST_REQ        = 2'd2,
      ST_BURST_WAIT = 2'd3
   } cap_state_t;

   // cfg_mode field encodings
   typedef enum logic [1:0] {
      MODE_OFF      = 2'b00,
      MODE_PERIODIC = 2'b01,
      MODE_ONESHOT  = 2'b10,
      MODE_EXTERNAL = 2'b11
   } cap_mode_t;

   localparam int unsigned DEF_FRAME_RATE   = 30;
   localparam int unsigned DEF_INTERVAL_SEC = 5;
   // Interval used when cfg_interval is programmed as 0 (frames)
   localparam int unsigned DEFAULT_INTERVAL = DEF_FRAME_RATE * DEF_INTERVAL_SEC;

endpackage

// File: rtl/capture_sched_ch.sv
// One capture channel: counts decoded frames, raises a held capture request
// per event (optionally a burst of them), and flags frames lost to an
// unacknowledged request.
// Build option: CAPTURE_STATS_EN adds a wrapping 16-bit accepted-ack counter.
module capture_sched_ch
   import frame_capture_pkg::*;
#(
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned BURST_W      = 4,
   parameter int unsigned DEF_INTERVAL = DEFAULT_INTERVAL
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               frame_done,
   input  logic [1:0]         cfg_mode,
   input  logic [CNT_W-1:0]   cfg_interval,
   input  logic [BURST_W-1:0] cfg_burst,
   input  logic               ext_trig,
   output logic               capture_req,
   input  logic               capture_ack,
   output logic               busy,
   output logic               overrun,
   input  logic               clr_overrun
`ifdef CAPTURE_STATS_EN
   ,
   output logic [15:0]        capture_count
`endif
);

   cap_state_t         r_state;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   r_interval;
   logic [BURST_W-1:0] r_burst_left;
   logic               r_req;
   logic               r_busy;
   logic               r_overrun;
   logic               r_oneshot_done;
`ifdef CAPTURE_STATS_EN
   logic [15:0]        r_capture_count;
`endif

   cap_mode_t          w_mode;
   logic [CNT_W-1:0]   w_interval;
   logic [BURST_W-1:0] w_burst_left;
   logic               w_ovr_set;

   // Decode configuration: effective interval and remaining-burst load value
   always_comb begin
      w_mode       = cap_mode_t'(cfg_mode);
      w_interval   = (cfg_interval == '0) ? CNT_W'(DEF_INTERVAL) : cfg_interval;
      w_burst_left = (cfg_burst == '0) ? '0 : cfg_burst - BURST_W'(1);
      w_ovr_set    = (r_state == ST_REQ) && frame_done && !capture_ack;
   end

   // Channel FSM with registered req/busy/overrun outputs
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state        <= ST_IDLE;
         r_cnt          <= '0;
         r_interval     <= '0;
         r_burst_left   <= '0;
         r_req          <= 1'b0;
         r_busy         <= 1'b0;
         r_overrun      <= 1'b0;
         r_oneshot_done <= 1'b0;
`ifdef CAPTURE_STATS_EN
         r_capture_count <= '0;
`endif
      end else begin
         if (w_ovr_set)
            r_overrun <= 1'b1;
         else if (clr_overrun)
            r_overrun <= 1'b0;

         // A completed one-shot stays parked in IDLE until the mode is changed
         if (w_mode != MODE_ONESHOT)
            r_oneshot_done <= 1'b0;

         if (w_mode == MODE_OFF) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_burst_left <= '0;
            r_req        <= 1'b0;
            r_busy       <= 1'b0;
         end else begin
            case (r_state)
               ST_IDLE: begin
                  if ((w_mode == MODE_PERIODIC) ||
                      ((w_mode == MODE_ONESHOT) && !r_oneshot_done)) begin
                     r_state    <= ST_COUNT;
                     r_cnt      <= '0;
                     r_interval <= w_interval;
                     r_busy     <= 1'b1;
                  end else if ((w_mode == MODE_EXTERNAL) && ext_trig) begin
                     r_state      <= ST_BURST_WAIT;
                     r_burst_left <= w_burst_left;
                     r_busy       <= 1'b1;
                  end
               end
               ST_COUNT: begin
                  if (frame_done) begin
                     if (r_cnt >= (r_interval - CNT_W'(1))) begin
                        r_state      <= ST_REQ;
                        r_cnt        <= '0;
                        r_burst_left <= w_burst_left;
                        r_req        <= 1'b1;
                     end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                     end
                  end
               end
               ST_REQ: begin
                  if (capture_ack) begin
                     r_req <= 1'b0;
`ifdef CAPTURE_STATS_EN
                     r_capture_count <= r_capture_count + 16'd1;
`endif
                     if (r_burst_left != '0) begin
                        r_state      <= ST_BURST_WAIT;
                        r_burst_left <= r_burst_left - BURST_W'(1);
                     end else if (w_mode == MODE_PERIODIC) begin
                        r_state    <= ST_COUNT;
                        r_cnt      <= '0;
                        r_interval <= w_interval;
                     end else begin
                        r_state        <= ST_IDLE;
                        r_busy         <= 1'b0;
                        r_oneshot_done <= (w_mode == MODE_ONESHOT);
                     end
                  end
               end
               ST_BURST_WAIT: begin
                  if (frame_done) begin
                     r_state <= ST_REQ;
                     r_req   <= 1'b1;
                  end
               end
               default: begin
                  r_state <= ST_IDLE;
                  r_req   <= 1'b0;
                  r_busy  <= 1'b0;
               end
            endcase
         end
      end
   end

   assign capture_req = r_req;
   assign busy        = r_busy;
   assign overrun     = r_overrun;
`ifdef CAPTURE_STATS_EN
   assign capture_count = r_capture_count;
`endif

endmodule

// File: rtl/frame_capture_scheduler.sv
// Multi-channel frame capture scheduler: NUM_CH independent capture_sched_ch
// instances with their configuration and handshake buses sliced per channel.
// Build option: CAPTURE_STATS_EN adds the capture_count output (16 bits/channel).
module frame_capture_scheduler
   import frame_capture_pkg::*;
#(
   parameter int unsigned NUM_CH       = 2,
   parameter int unsigned CNT_W        = 16,
   parameter int unsigned BURST_W      = 4,
   parameter int unsigned FRAME_RATE   = DEF_FRAME_RATE,
   parameter int unsigned INTERVAL_SEC = DEF_INTERVAL_SEC
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [NUM_CH-1:0]          frame_done,
   input  logic [2*NUM_CH-1:0]        cfg_mode,
   input  logic [CNT_W*NUM_CH-1:0]    cfg_interval,
   input  logic [BURST_W*NUM_CH-1:0]  cfg_burst,
   input  logic [NUM_CH-1:0]          ext_trig,
   output logic [NUM_CH-1:0]          capture_req,
   input  logic [NUM_CH-1:0]          capture_ack,
   output logic [NUM_CH-1:0]          busy,
   output logic [NUM_CH-1:0]          overrun,
   input  logic [NUM_CH-1:0]          clr_overrun
`ifdef CAPTURE_STATS_EN
   ,
   output logic [16*NUM_CH-1:0]       capture_count
`endif
);

   localparam int unsigned DEF_IVL = FRAME_RATE * INTERVAL_SEC;

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      capture_sched_ch #(
         .CNT_W        (CNT_W),
         .BURST_W      (BURST_W),
         .DEF_INTERVAL (DEF_IVL)
      ) u_ch (
         .clk          (clk),
         .reset        (reset),
         .frame_done   (frame_done[g]),
         .cfg_mode     (cfg_mode[2*g +: 2]),
         .cfg_interval (cfg_interval[CNT_W*g +: CNT_W]),
         .cfg_burst    (cfg_burst[BURST_W*g +: BURST_W]),
         .ext_trig     (ext_trig[g]),
         .capture_req  (capture_req[g]),
         .capture_ack  (capture_ack[g]),
         .busy         (busy[g]),
         .overrun      (overrun[g]),
         .clr_overrun  (clr_overrun[g])
`ifdef CAPTURE_STATS_EN
         ,
         .capture_count(capture_count[16*g +: 16])
`endif
      );
   end

endmodule
